// File: rtl/hilo_muldiv_unit_if.sv
// HI/LO multiply/divide issue and write-back bundle.
// EX drives the issue side; the unit drives the write pulse and stall.
interface hilo_muldiv_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        rhl_wr;
  logic [1:0]  rhl_sel_wr;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output start, op, src_a, src_b, flush,
    input  busy, rhl_wr, rhl_sel_wr,
    input  hi_out, lo_out
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output busy, rhl_wr, rhl_sel_wr,
    output hi_out, lo_out
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO writer: MULT/MULTU/DIV/DIVU/MTHI/MTLO with busy stall.
// MULDIV_DIVZERO_FAST_EN: divide by zero completes in one cycle.
module hilo_muldiv_unit #(
  parameter int unsigned MUL_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  hilo_muldiv_unit_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [2:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic        sgn_q, sgn_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic        wr_q, wr_d;
  logic [1:0]  sel_q, sel_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic signed [32:0] ma, mb;
  logic signed [63:0] prod;
  logic [33:0]        trial;
  logic               sgn_in;
  logic               nega, negb;

  assign ma = {sgn_q & a_q[31], a_q};
  assign mb = {sgn_q & b_q[31], b_q};
  assign prod = ma * mb;

  // Bit 33 is the borrow: set when the divisor does not fit.
  assign trial = {1'b0, rem_q, quo_q[31]} - {2'b00, b_q};

  assign sgn_in = ~bus.op[0];
  assign nega   = sgn_in & bus.src_a[31];
  assign negb   = sgn_in & bus.src_b[31];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    wr_d    = 1'b0;
    sel_d   = sel_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              a_d     = bus.src_a;
              b_d     = bus.src_b;
              sgn_d   = sgn_in;
              cnt_d   = 5'(MUL_LAT - 1);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
`ifdef MULDIV_DIVZERO_FAST_EN
              if (bus.src_b == 32'd0) begin
                state_d = S_DONE;
                wr_d    = 1'b1;
                sel_d   = 2'b10;
                hi_d    = bus.src_a;
                lo_d    = 32'hFFFF_FFFF;
              end else begin
`else
              begin
`endif
                quo_d   = nega ? -bus.src_a : bus.src_a;
                b_d     = negb ? -bus.src_b : bus.src_b;
                rem_d   = 32'd0;
                negq_d  = nega ^ negb;
                negr_d  = nega;
                cnt_d   = 5'd31;
                state_d = S_DIV;
              end
            end
            OP_MTHI: begin
              state_d = S_DONE;
              wr_d    = 1'b1;
              sel_d   = 2'b01;
              hi_d    = bus.src_a;
              lo_d    = 32'd0;
            end
            OP_MTLO: begin
              state_d = S_DONE;
              wr_d    = 1'b1;
              sel_d   = 2'b00;
              hi_d    = 32'd0;
              lo_d    = bus.src_a;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == 5'd0) begin
          state_d = S_DONE;
          wr_d    = 1'b1;
          sel_d   = 2'b10;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_DIV: begin
        if (trial[33]) begin
          rem_d = {rem_q[30:0], quo_q[31]};
          quo_d = {quo_q[30:0], 1'b0};
        end else begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end
        if (cnt_q == 5'd0) state_d = S_FIX;
        else cnt_d = cnt_q - 5'd1;
      end
      S_FIX: begin
        state_d = S_DONE;
        wr_d    = 1'b1;
        sel_d   = 2'b10;
        lo_d    = negq_q ? -quo_q : quo_q;
        hi_d    = negr_q ? -rem_q : rem_q;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flush aborts whatever is in flight and cancels any pending write.
    if (bus.flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      wr_d    = 1'b0;
      sel_d   = sel_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      wr_q    <= 1'b0;
      sel_q   <= 2'b00;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      wr_q    <= wr_d;
      sel_q   <= sel_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE) && (state_q != S_DONE);
  // A flush landing in the DONE cycle must still kill the pulse.
  assign bus.rhl_wr     = wr_q & ~bus.flush;
  assign bus.rhl_sel_wr = sel_q;
  assign bus.hi_out     = hi_q;
  assign bus.lo_out     = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: vector table plus
// flush, reset, busy-ignore and invalid-op sequences.
module tb_hilo_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hilo_muldiv_unit_if bus();

  hilo_muldiv_unit #(.MUL_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  sel;
  } vec_t;

  localparam int NV = 11;
`ifdef MULDIV_DIVZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 34;
`endif

  vec_t tbl [NV];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int nbusy;
    lat   = 0;
    nbusy = 0;
    issue(v.op, v.a, v.b);
    for (int k = 1; k <= 60; k++) begin
      if (bus.rhl_wr) begin
        lat = k;
        break;
      end
      if (bus.busy) nbusy++;
      @(negedge clk);
    end
    chk({v.name, " lat"}, lat, v.lat);
    chk({v.name, " busy"}, nbusy, v.lat - 1);
    chk({v.name, " busy_done"}, {31'd0, bus.busy}, 32'd0);
    chk({v.name, " hi"}, bus.hi_out, v.hi);
    chk({v.name, " lo"}, bus.lo_out, v.lo);
    chk({v.name, " sel"}, {30'd0, bus.rhl_sel_wr}, {30'd0, v.sel});
    @(negedge clk);
    chk({v.name, " wr_end"}, {31'd0, bus.rhl_wr}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr;
    int wk;
    logic [31:0] whi, wlo;

    tbl[0]  = '{"mult_neg", 3'b000, 32'hFFFF_FFFE, 32'd3,
                3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2'b10};
    tbl[1]  = '{"multu", 3'b001, 32'hFFFF_FFFE, 32'd3,
                3, 32'h0000_0002, 32'hFFFF_FFFA, 2'b10};
    tbl[2]  = '{"mult_min", 3'b000, 32'h8000_0000, 32'h8000_0000,
                3, 32'h4000_0000, 32'h0000_0000, 2'b10};
    tbl[3]  = '{"multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                3, 32'hFFFF_FFFE, 32'h0000_0001, 2'b10};
    tbl[4]  = '{"divu", 3'b011, 32'd100, 32'd7,
                34, 32'd2, 32'd14, 2'b10};
    tbl[5]  = '{"div_nega", 3'b010, 32'hFFFF_FF9C, 32'd7,
                34, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 2'b10};
    tbl[6]  = '{"div_negb", 3'b010, 32'd100, 32'hFFFF_FFF9,
                34, 32'd2, 32'hFFFF_FFF2, 2'b10};
    tbl[7]  = '{"div_wrap", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF,
                34, 32'd0, 32'h8000_0000, 2'b10};
    tbl[8]  = '{"mtlo", 3'b101, 32'h1234_5678, 32'd0,
                1, 32'd0, 32'h1234_5678, 2'b00};
    tbl[9]  = '{"mthi", 3'b100, 32'hDEAD_BEEF, 32'd0,
                1, 32'hDEAD_BEEF, 32'd0, 2'b01};
    tbl[10] = '{"divu_zero", 3'b011, 32'd9, 32'd0,
                DZ_LAT, 32'd9, 32'hFFFF_FFFF, 2'b10};

    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    bus.flush = 1'b0;

    @(negedge clk);
    chk("rst wr", {31'd0, bus.rhl_wr}, 32'd0);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst sel", {30'd0, bus.rhl_sel_wr}, 32'd0);
    chk("rst hi", bus.hi_out, 32'd0);
    chk("rst lo", bus.lo_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(tbl[i]);

    // Invalid op: no write, no busy.
    issue(3'b110, 32'd1, 32'd1);
    nwr = 0;
    for (int k = 1; k <= 5; k++) begin
      if (bus.rhl_wr || bus.busy) nwr++;
      @(negedge clk);
    end
    chk("badop", nwr, 0);

    // Start with flush in IDLE: flush wins.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 3'b101;
    bus.src_a = 32'h5555_5555;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("stflush wr", {31'd0, bus.rhl_wr}, 32'd0);
    chk("stflush busy", {31'd0, bus.busy}, 32'd0);

    // Flush in the DONE cycle suppresses the pulse.
    issue(3'b101, 32'hAAAA_0001, 32'd0);
    bus.flush = 1'b1;
    #1;
    chk("doneflush wr", {31'd0, bus.rhl_wr}, 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("doneflush wr2", {31'd0, bus.rhl_wr}, 32'd0);

    // DIVU flushed at T+10, MULTU 5x6 issued at T+12.
    issue(3'b011, 32'd100, 32'd7);
    nwr = 0;
    wk  = 0;
    whi = 32'hX;
    wlo = 32'hX;
    for (int k = 1; k <= 40; k++) begin
      if (bus.rhl_wr) begin
        nwr++;
        wk  = k;
        whi = bus.hi_out;
        wlo = bus.lo_out;
      end
      if (k == 10) chk("fl busy_pre", {31'd0, bus.busy}, 32'd1);
      if (k == 11) chk("fl busy", {31'd0, bus.busy}, 32'd0);
      bus.flush = (k == 10);
      bus.start = (k == 12);
      if (k == 12) begin
        bus.op    = 3'b001;
        bus.src_a = 32'd5;
        bus.src_b = 32'd6;
      end
      @(negedge clk);
    end
    chk("fl nwr", nwr, 1);
    chk("fl wk", wk, 15);
    chk("fl hi", whi, 32'd0);
    chk("fl lo", wlo, 32'd30);

    // Start while busy is ignored.
    issue(3'b011, 32'd100, 32'd7);
    nwr = 0;
    wk  = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.rhl_wr) begin
        nwr++;
        wk  = k;
        wlo = bus.lo_out;
      end
      bus.start = (k == 5);
      bus.op    = 3'b101;
      bus.src_a = 32'h0000_0077;
      @(negedge clk);
    end
    chk("ign nwr", nwr, 1);
    chk("ign wk", wk, 34);
    chk("ign lo", wlo, 32'd14);

    // Asynchronous reset mid-divide.
    issue(3'b011, 32'd50, 32'd3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst busy", {31'd0, bus.busy}, 32'd0);
    chk("mrst wr", {31'd0, bus.rhl_wr}, 32'd0);
    chk("mrst hi", bus.hi_out, 32'd0);
    chk("mrst lo", bus.lo_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nwr = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.rhl_wr || bus.busy) nwr++;
      @(negedge clk);
    end
    chk("mrst quiet", nwr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Writer side of the HI/LO forwarding path. It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from EX.
- Produces the HI/LO write pulse with the RHLWr/RHLSelWr encoding that the HI/LO forwarding mux consumes.
- Raises a busy stall request while a multi-cycle operation is in flight.
- Sits beside the ALU in EX. Its outputs feed the EX_MEM HI/LO write fields.

Parameters:
- MUL_LAT, 2, multiply latency in cycles from accept to write pulse minus one (range 1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  issue strobe; sampled only when busy=0.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others ignored.
- src_a  in  32  rs operand (dividend / multiplicand / MT data).
- src_b  in  32  rt operand (divisor / multiplier).
- flush  in  1  exception/eret flush; aborts the in-flight operation.
- busy  out  1  stall request to the hazard unit.
- rhl_wr  out  1  one-cycle HI/LO write pulse.
- rhl_sel_wr  out  2  00 LO only, 01 HI only, 10 both.
- hi_out  out  32  HI write data.
- lo_out  out  32  LO write data.

Behaviour:
- Reset values: all outputs 0; state IDLE; iteration counter 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - An accepted start (start=1, flush=0, valid op) in cycle T moves the unit to MUL/DIV, or to DONE for MTHI/MTLO.
  - Operands are latched at T.
  - Invalid op or start with flush=1 → stay IDLE, no write.
- MTHI/MTLO:
  - DONE at T+1.
  - rhl_wr=1, rhl_sel_wr=01 (MTHI) or 00 (MTLO).
  - The written half is src_a. The other data output is 0.
- MUL:
  - MUL_LAT cycles (T+1..T+MUL_LAT), then DONE.
  - Product is 64-bit, signed for MULT and unsigned for MULTU.
  - hi_out = product[63:32], lo_out = product[31:0], rhl_sel_wr=10.
- DIV:
  - Radix-2 restoring divide on the magnitudes, 32 iterations (T+1..T+32, counter 31→0).
  - Then FIX (T+33): conditional negation.
  - Then DONE (T+34).
- Signed division rules:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0 (two's-complement wrap).
  - LO=quotient, HI=remainder, rhl_sel_wr=10.
- Divide by zero (no macro): full latency. Unsigned result LO=0xFFFFFFFF, HI=dividend. Signed result is the same magnitude result after FIX.
- DONE:
  - rhl_wr=1 for exactly one cycle with registered data, then IDLE.
  - The outputs rhl_wr, rhl_sel_wr, hi_out and lo_out are registered. The write pulse appears only while in DONE.
  - rhl_sel_wr, hi_out and lo_out keep their last values when idle.
- busy:
  - busy = (state != IDLE) && (state != DONE), registered-state based.
  - busy is high T+1 through the cycle before DONE. It is 0 in the DONE cycle so the dependent instruction advances into the bypass window.
- start while busy=1 is ignored, with no queueing.
- Once an operation is accepted in cycle T, start in the following cycles (including the DONE cycle) is not sampled until the unit is back in IDLE.
- flush:
  - In any non-IDLE state: next state IDLE, rhl_wr forced 0 that cycle and the next, busy 0 next cycle.
  - flush in the DONE cycle suppresses rhl_wr.
  - flush together with start: flush wins.
- Reset mid-operation: immediate return to IDLE, outputs cleared, no write.

Optional Feature:
- Macro: MULDIV_DIVZERO_FAST_EN.
- Defined: DIV/DIVU with src_b==0 skips the DIV and FIX states. DONE is reached at T+1 with LO=0xFFFFFFFF, HI=src_a, for both signed and unsigned.
- Undefined: divide by zero takes the normal 34-cycle path, with results as stated under Behaviour.

Test Plan:
- MULT src_a=0xFFFFFFFE, src_b=3, MUL_LAT=2 → busy T+1..T+2; rhl_wr at T+3; HI=0xFFFFFFFF, LO=0xFFFFFFFA, sel=10.
- DIVU 100/7 → busy T+1..T+33; rhl_wr at T+34; LO=14, HI=2.
- DIV 0xFFFFFF9C(-100)/7 → LO=0xFFFFFFF2, HI=0xFFFFFFFE. Also DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTLO src_a=0x12345678 → rhl_wr at T+1, sel=00, lo_out=0x12345678, busy never asserted.
- DIVU started, flush at T+10 → busy 0 at T+11, no rhl_wr through T+40. A new MULTU 5×6 accepted at T+12 → HI=0, LO=30.
- DIVU 9/0 → LO=0xFFFFFFFF, HI=9. rhl_wr at T+34 without MULDIV_DIVZERO_FAST_EN, at T+1 with it. A start while busy is ignored (no extra write).
